regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Shares the register file's single write port between two writeback requesters: the execute-stage ALU result (port 0) and the memory-stage load result (port 1). Each cycle it grants at most one requester, registers the winning 5-bit address, 64-bit data and enable, and drives the register file's 5-to-32 write-address decoder. Load results win by default. A wait counter guarantees the ALU port is never starved.

## Interface

Parameters:
- DATA_W, 64: width of write data.
- STARVE_LIMIT, 3: number of consecutive lost cycles on port 0 before port 0 is forced to win. Legal range 1..7.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- hold  input  1  pipeline stall; while high, no grants are issued.
- v0  input  1  port 0 (ALU) write request valid.
- a0  input  5  port 0 destination register.
- d0  input  DATA_W  port 0 write data.
- r0  output  1  port 0 ready; combinational.
- v1  input  1  port 1 (load) write request valid.
- a1  input  5  port 1 destination register.
- d1  input  DATA_W  port 1 write data.
- r1  output  1  port 1 ready; combinational.
- wr_en  output  1  registered; drives the decoder enable.
- wr_addr  output  5  registered; drives the decoder select input.
- wr_data  output  DATA_W  registered write data.
- starved  output  1  registered; high while the FSM is in FORCE0.

## Operation

- A transfer on port i occurs in any cycle where vi and ri are both high. A requester holds ai and di stable until its transfer.
- FSM states:
  - NORMAL: grant goes to port 1 if v1 is high, else to port 0.
  - FORCE0: grant goes to port 0. Port 1 waits.
- Ready rule: ri = grant_i & ~hold & ~reset. At most one of r0 and r1 is high in any cycle. ri never depends on vi of the same port beyond the grant rule.
- Wait counter w0 (3 bits):
  - In NORMAL, w0 increments when v0 & v1 & ~hold, i.e. port 0 loses.
  - w0 clears on any port 0 transfer, or when v0 is low.
  - w0 is unchanged while hold is high.
  - NORMAL moves to FORCE0 on the edge where the incremented w0 equals STARVE_LIMIT.
- FORCE0 moves to NORMAL on the edge of the port 0 transfer. w0 clears on that edge.
  - If v0 drops while in FORCE0, the FSM returns to NORMAL and w0 clears.
- Zero register: a transfer with address 31 (XZR) is accepted. It produces wr_en=0 on the next cycle, and wr_addr/wr_data hold their previous values.
- Output register:
  - On a transfer of a non-31 address: wr_en=1, and wr_addr/wr_data take the granted port's values.
  - Otherwise: wr_en=0, and wr_addr/wr_data hold their previous values.
- Same-cycle same-address requests: only the granted port writes. The other writes on a later cycle, so the final register value comes from whichever port transfers last.

## Timing

- Reset values: wr_en=0, wr_addr=0, wr_data=0, starved=0, FSM=NORMAL, w0=0.
- r0 and r1 are 0 while reset is asserted. Asserting reset mid-operation discards any request in flight; no write is issued for it.
- Latency: a transfer in cycle N produces wr_en/wr_addr/wr_data in cycle N+1, valid for exactly one cycle.
- Throughput: one write per cycle sustained.
- hold freezes the FSM and w0 and forces wr_en=0 on the next cycle. It takes effect in the same cycle it is asserted, because r0 and r1 drop combinationally.
- starved rises the cycle after the NORMAL->FORCE0 edge and falls the cycle after the FORCE0->NORMAL edge.

## Test plan

- Reset, then a single request: v0=1, a0=5, d0=0xAA → r0=1 in cycle N. Next cycle wr_en=1, wr_addr=5, wr_data=0xAA. The cycle after, wr_en=0.
- Simultaneous requests: v0=1/a0=3 and v1=1/a1=4, STARVE_LIMIT=3.
  - Cycle N: r1=1, r0=0; port 1 transfers with a1=4.
  - Keep v1 asserted with new addresses. After 3 consecutive losses, starved=1 and port 0 transfers (wr_addr=3).
  - Then FSM returns to NORMAL and w0=0.
- XZR: v1=1, a1=31, d1=0xFF → r1=1. Next cycle wr_en=0, and wr_addr/wr_data unchanged from the prior write.
- hold=1 with v0=v1=1 for 4 cycles → r0=r1=0 and wr_en=0 throughout; w0 and FSM unchanged. On hold release, port 1 transfers first.
- Reset mid-operation: FSM in FORCE0 with v0=1, assert reset asynchronously → immediately wr_en=0, starved=0, r0=0. After release, FSM=NORMAL and w0=0.
- Full sweep: port 0 writes addresses 0..30 back-to-back with d0=addr → wr_en high for 31 consecutive cycles, with wr_addr matching each address one cycle later.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: arbitrates the ALU and load writebacks onto the single register-file write port.
// Loads win by default; a wait counter forces an ALU grant after STARVE_LIMIT consecutive losses.
module regfile_wr_arbiter #(
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              v0,
    input  logic [4:0]        a0,
    input  logic [DATA_W-1:0] d0,
    output logic              r0,
    input  logic              v1,
    input  logic [4:0]        a1,
    input  logic [DATA_W-1:0] d1,
    output logic              r1,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              starved
);
    typedef enum logic {NORMAL, FORCE0} state_t;
    localparam logic [2:0] LIM = 3'(STARVE_LIMIT);
    state_t state;
    logic [2:0] w0, w0n;
    logic g1, t0, t1, we0, we1;
    assign g1  = (state == NORMAL) & v1;
    assign r1  = g1 & ~hold & ~reset;
    assign r0  = ~g1 & ~hold & ~reset;
    assign t0  = v0 & r0;
    assign t1  = v1 & r1;
    assign we0 = t0 & (a0 != 5'd31);
    assign we1 = t1 & (a1 != 5'd31);
    assign w0n = w0 + 3'd1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= NORMAL;
            w0      <= '0;
            starved <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= we0 | we1;
            if (we0) begin
                wr_addr <= a0;
                wr_data <= d0;
            end else if (we1) begin
                wr_addr <= a1;
                wr_data <= d1;
            end
            // In NORMAL with both valid, port 0 has lost this cycle; FORCE0 always exits once unheld.
            if (!hold) begin
                if (state == FORCE0 || t0 || !v0) begin
                    state   <= NORMAL;
                    w0      <= '0;
                    starved <= 1'b0;
                end else if (v1) begin
                    w0 <= w0n;
                    if (w0n == LIM) begin
                        state   <= FORCE0;
                        starved <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
